ayatsuki_lsu: RTL and testbench

//  Parametrised load/store unit between the EX stage and a handshaked data bus.

---
 rtl/ayatsuki_lsu_if.sv | 40 ++++
 rtl/ayatsuki_lsu.sv | 173 +++++++++++++++++
 tb/tb_ayatsuki_lsu.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ayatsuki_lsu_if.sv
// EX-side request, ctrl stall, data-bus and writeback signals of the load/store unit.
// master = the LSU itself, slave = its environment (EX/ctrl/bus/writeback).
interface ayatsuki_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_we_i;
    logic [2:0]        req_type_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic [4:0]        req_rd_i;
    logic              stall_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [31:0]       bus_wdata_o;
    logic [3:0]        bus_be_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [31:0]       bus_rdata_i;
    logic              wb_valid_o;
    logic [4:0]        wb_rd_o;
    logic [31:0]       wb_data_o;
    logic              exc_o;
    logic [1:0]        exc_code_o;

    modport master (
        input  req_valid_i, req_we_i, req_type_i, req_addr_i, req_wdata_i, req_rd_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output wb_valid_o, wb_rd_o, wb_data_o, exc_o, exc_code_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_type_i, req_addr_i, req_wdata_i, req_rd_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, exc_o, exc_code_o
    );
endinterface

// File: rtl/ayatsuki_lsu.sv
// Load/store unit: one request in flight over a req/gnt/rvalid bus; aligned, extended load writeback.
// Latency: bus_req one cycle after accept, wb/exc one cycle after completion; stalls EX while busy.
module ayatsuki_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    ayatsuki_lsu_if.master lsu
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [4:0]        rd;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } txn_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    txn_t             txn_q, txn_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             exc_q, exc_d;
    logic [1:0]       exc_code_q, exc_code_d;

    logic        type_ok, misal, accept, done, stall, tmo_hit;
    logic [1:0]  off;
    logic [3:0]  new_be;
    logic [31:0] new_wdata, ld_shift, ld_data;

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        type_ok = 1'b0;
        misal   = 1'b0;
        case (lsu.req_type_i)
            3'b000: type_ok = 1'b1;
            3'b001: begin type_ok = 1'b1; misal = lsu.req_addr_i[0]; end
            3'b010: begin type_ok = 1'b1; misal = |lsu.req_addr_i[1:0]; end
            3'b100: type_ok = ~lsu.req_we_i;
            3'b101: begin type_ok = ~lsu.req_we_i; misal = lsu.req_addr_i[0]; end
            default: type_ok = 1'b0;
        endcase
        accept = lsu.req_valid_i & type_ok & ~misal;
    end

    // Store data is replicated across lanes; byte enables pick the live ones.
    always_comb begin
        off = lsu.req_addr_i[1:0];
        case (lsu.req_type_i[1:0])
            2'b00: begin
                new_be    = 4'b0001 << off;
                new_wdata = {4{lsu.req_wdata_i[7:0]}};
            end
            2'b01: begin
                new_be    = 4'b0011 << off;
                new_wdata = {2{lsu.req_wdata_i[15:0]}};
            end
            default: begin
                new_be    = 4'hF;
                new_wdata = lsu.req_wdata_i;
            end
        endcase
    end

    always_comb begin
        ld_shift = lsu.bus_rdata_i >> {txn_q.addr[1:0], 3'b000};
        case (txn_q.typ)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = lsu.bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        exc_d      = 1'b0;
        exc_code_d = 2'b00;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = S_REQ;
                    cnt_d   = '0;
                    txn_d   = '{we: lsu.req_we_i, typ: lsu.req_type_i, addr: lsu.req_addr_i,
                                rd: lsu.req_rd_i, wdata: new_wdata, be: new_be};
                end else if (lsu.req_valid_i) begin
                    exc_d      = 1'b1;
                    exc_code_d = !type_ok ? 2'b11 : (lsu.req_we_i ? 2'b10 : 2'b01);
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                done  = (state_q == S_REQ) ? (lsu.bus_gnt_i & lsu.bus_rvalid_i) : lsu.bus_rvalid_i;
                stall = (state_q == S_REQ) | ~lsu.bus_rvalid_i;
                // Completion takes priority over an expiring timeout in the same cycle.
                if (done) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    state_d    = S_IDLE;
                    stall      = 1'b0;
                    exc_d      = 1'b1;
                    exc_code_d = 2'b11;
                end else if (state_q == S_REQ && lsu.bus_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (done && !txn_q.we) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = txn_q.rd;
            wb_data_d  = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            txn_q      <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    assign lsu.stall_o     = stall;
    assign lsu.bus_req_o   = (state_q == S_REQ);
    assign lsu.bus_we_o    = txn_q.we;
    assign lsu.bus_addr_o  = {txn_q.addr[ADDR_W-1:2], 2'b00};
    assign lsu.bus_wdata_o = txn_q.wdata;
    assign lsu.bus_be_o    = txn_q.be;
    assign lsu.wb_valid_o  = wb_valid_q;
    assign lsu.wb_rd_o     = wb_rd_q;
    assign lsu.wb_data_o   = wb_data_q;
    assign lsu.exc_o       = exc_q;
    assign lsu.exc_code_o  = exc_code_q;

endmodule

// File: tb/tb_ayatsuki_lsu.sv
// Scoreboarded bench for ayatsuki_lsu: directed corner cases, then randomized requests and bus delays.
module tb_ayatsuki_lsu;
    localparam int TMO = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ayatsuki_lsu_if #(.ADDR_W(32)) bif ();
    ayatsuki_lsu #(.ADDR_W(32), .TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .lsu(bif.master)
    );

    typedef struct {
        bit          is_exc;
        logic [1:0]  code;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return |{bif.stall_o, bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o, bif.bus_wdata_o,
                 bif.bus_be_o, bif.wb_valid_o, bif.wb_rd_o, bif.wb_data_o, bif.exc_o, bif.exc_code_o};
    endfunction

    // Pick the addressed bytes out of the bus word, then extend.
    function automatic logic [31:0] load_model(input logic [31:0] rdata, input int off,
                                               input int size, input bit sgn);
        longint v = 0;
        for (int i = 0; i < size; i++)
            v = v | (longint'((rdata >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (sgn && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic clear_inputs();
        bif.req_valid_i  = 1'b0;
        bif.req_we_i     = 1'b0;
        bif.req_type_i   = 3'b000;
        bif.req_addr_i   = '0;
        bif.req_wdata_i  = '0;
        bif.req_rd_i     = '0;
        bif.bus_gnt_i    = 1'b0;
        bif.bus_rvalid_i = 1'b0;
        bif.bus_rdata_i  = '0;
    endtask

    // g: REQ cycles before the grant cycle; r: cycles from grant to rvalid (0 = same cycle).
    task automatic do_txn(input bit we, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input int g, input int r, input logic [31:0] rdata);
        int size, off;
        bit legal, aligned, completes;
        exp_t e;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        legal   = (typ <= 3'd2) || (!we && (typ == 3'd4 || typ == 3'd5));
        size    = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
        off     = int'(addr[1:0]);
        aligned = (off % size) == 0;
        completes = (g + r) <= (TMO - 1);
        exp_wd = '0;
        exp_be = '0;
        for (int lane = 0; lane < 4; lane++) begin
            exp_wd = exp_wd | (((wdata >> (8 * (lane % size))) & 32'hFF) << (8 * lane));
            if (lane >= off && lane < off + size) exp_be[lane] = 1'b1;
        end
        e.rd = '0; e.data = '0; e.code = '0; e.is_exc = 1'b0;
        if (!legal || !aligned) begin
            e.is_exc = 1'b1;
            e.code   = !legal ? 2'b11 : (we ? 2'b10 : 2'b01);
            sb.push_back(e);
        end else if (!completes) begin
            e.is_exc = 1'b1;
            e.code   = 2'b11;
            sb.push_back(e);
        end else if (!we) begin
            e.rd   = rd;
            e.data = load_model(rdata, off, size, !typ[2]);
            sb.push_back(e);
        end

        @(posedge clk); #1;
        bif.req_valid_i = 1'b1;
        bif.req_we_i    = we;
        bif.req_type_i  = typ;
        bif.req_addr_i  = addr;
        bif.req_wdata_i = wdata;
        bif.req_rd_i    = rd;
        @(negedge clk);
        chk("stall_accept", {31'b0, bif.stall_o}, {31'b0, legal && aligned});
        if (!legal || !aligned) begin
            @(posedge clk); #1;
            bif.req_valid_i = 1'b0;
            @(negedge clk);
            chk("reject_no_bus_req", {31'b0, bif.bus_req_o}, 32'd0);
            return;
        end

        for (int idx = 0; idx < TMO; idx++) begin
            @(posedge clk); #1;
            bif.req_valid_i  = 1'b0;
            bif.bus_gnt_i    = (idx == g);
            bif.bus_rvalid_i = (idx == g + r);
            bif.bus_rdata_i  = (idx == g + r) ? rdata : $urandom;
            @(negedge clk);
            chk("bus_req", {31'b0, bif.bus_req_o}, {31'b0, idx <= g});
            chk("stall_busy", {31'b0, bif.stall_o},
                {31'b0, !((idx == g + r && r > 0) || (!completes && idx == TMO - 1))});
            if (idx == 0) begin
                chk("bus_addr", bif.bus_addr_o, addr & 32'hFFFF_FFFC);
                chk("bus_we", {31'b0, bif.bus_we_o}, {31'b0, we});
                chk("bus_be", {28'b0, bif.bus_be_o}, {28'b0, exp_be});
                chk("bus_wdata", bif.bus_wdata_o, exp_wd);
            end
            if (idx == g + r) break;
        end
        @(posedge clk); #1;
        bif.bus_gnt_i    = 1'b0;
        bif.bus_rvalid_i = 1'b0;
        if (!completes) begin
            // A late response after the abort must be ignored.
            bif.bus_gnt_i    = 1'b1;
            bif.bus_rvalid_i = 1'b1;
            @(negedge clk);
            chk("late_stall", {31'b0, bif.stall_o}, 32'd0);
            chk("late_bus_req", {31'b0, bif.bus_req_o}, 32'd0);
            @(posedge clk); #1;
            bif.bus_gnt_i    = 1'b0;
            bif.bus_rvalid_i = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bif.wb_valid_o === 1'b1 || bif.exc_o === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got wb_valid=%0b exc=%0b with empty scoreboard",
                             bif.wb_valid_o, bif.exc_o);
                end else begin
                    e = sb.pop_front();
                    chk("out_kind_exc", {31'b0, bif.exc_o}, {31'b0, e.is_exc});
                    chk("out_kind_wb", {31'b0, bif.wb_valid_o}, {31'b0, !e.is_exc});
                    if (e.is_exc) begin
                        chk("exc_code", {30'b0, bif.exc_code_o}, {30'b0, e.code});
                    end else begin
                        chk("wb_rd", {27'b0, bif.wb_rd_o}, {27'b0, e.rd});
                        chk("wb_data", bif.wb_data_o, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : stimulus
        bit          we;
        logic [2:0]  typ;
        logic [31:0] addr;
        int          g;
        int          pick;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {31'b0, any_out()}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 0, 1, 32'hDEAD_BEEF);
        do_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 0, 1, 32'h80AA_5511);
        do_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 0, 1, 32'h80AA_5511);
        do_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd8, 0, 0, 32'h80AA_5511);
        do_txn(1'b1, 3'b001, 32'h0000_0002, 32'h1234_ABCD, 5'd0, 3, 1, 32'h0);
        do_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 0, 1, 32'h0);
        do_txn(1'b1, 3'b010, 32'h0000_0102, 32'h5555_AAAA, 5'd0, 0, 1, 32'h0);
        do_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd3, 0, 1, 32'h0);
        do_txn(1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd3, 0, 1, 32'h0);
        do_txn(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd4, 100, 0, 32'h0);
        do_txn(1'b0, 3'b001, 32'h0000_0206, 32'h0, 5'd4, 5, 0, 32'h0000_F00D);
        do_txn(1'b0, 3'b001, 32'h0000_0206, 32'h0, 5'd4, 5, 1, 32'h0);

        // Reset while waiting for rvalid: no writeback, no exception.
        @(posedge clk); #1;
        bif.req_valid_i = 1'b1;
        bif.req_we_i    = 1'b0;
        bif.req_type_i  = 3'b010;
        bif.req_addr_i  = 32'h0000_0300;
        bif.req_rd_i    = 5'd11;
        @(posedge clk); #1;
        bif.req_valid_i = 1'b0;
        bif.bus_gnt_i   = 1'b1;
        @(posedge clk); #1;
        bif.bus_gnt_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wait_stall", {31'b0, bif.stall_o}, 32'd1);
        @(posedge clk); #1;
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("midrst_outputs", {31'b0, any_out()}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bif.bus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("post_rst_bus_req", {31'b0, bif.bus_req_o}, 32'd0);
        do_txn(1'b0, 3'b010, 32'h0000_0304, 32'h0, 5'd12, 0, 1, 32'h0BAD_CAFE);

        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            typ  = (pick < 8) ? 3'(pick) : 3'b010;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr[1:0] = (typ[1:0] == 2'd2) ? 2'b00 :
                            (typ[1:0] == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
            g = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
            do_txn(we, typ, addr, $urandom, 5'($urandom_range(0, 31)),
                   g, $urandom_range(0, 3), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
